// File: rtl/booth8_ctrl.sv
// Sequencing FSM for the 15-bit radix-8 Booth multiplier datapath.
// Optional BOOTH8_ZERO_SKIP_EN: a zero Booth digit shifts directly from EVAL.
module booth8_ctrl #(
    parameter int MAX_DIGITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [14:0] mcand,
    input  logic [14:0] mplier,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        dp_rst,
    output logic [14:0] data_out,
    output logic        ldM,
    output logic        ldQ,
    output logic        ldA,
    output logic        shift,
    output logic        addsub,
    output logic [1:0]  Num,
    input  logic [2:0]  dp_q0,
    input  logic        dp_qm1,
    input  logic        dp_zero
);
    localparam int CW = $clog2(MAX_DIGITS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_LDM, S_LDQ, S_EVAL, S_SHIFT, S_DONE
    } state_t;

    state_t        r_state;
    logic [14:0]   r_mcand;
    logic [14:0]   r_mplier;
    logic [CW-1:0] r_cnt;
    logic          r_err;

    logic [2:0]    w_pos;
    logic [3:0]    w_digit;
    logic [3:0]    w_abs;
    logic          w_neg;
    logic          w_nz;
    logic          w_cnt_max;
    logic          w_dec;

    // Digit d = -4*q2 + 2*q1 + q0 + qm1 in 4-bit two's complement.
    assign w_pos     = {1'b0, dp_q0[1:0]} + {2'b00, dp_qm1};
    assign w_digit   = {1'b0, w_pos} - {1'b0, dp_q0[2], 2'b00};
    assign w_neg     = w_digit[3];
    assign w_abs     = w_neg ? (4'd0 - w_digit) : w_digit;
    assign w_nz      = (w_digit != 4'd0);
    assign w_cnt_max = (r_cnt == CW'(MAX_DIGITS));
    assign w_dec     = (r_state == S_EVAL) && !dp_zero && !w_cnt_max;

    // Decode outputs follow the registered datapath status within the EVAL cycle.
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign err      = (r_state == S_DONE) && r_err;
    assign dp_rst   = rst || (r_state == S_CLR);
    assign ldM      = (r_state == S_LDM);
    assign ldQ      = (r_state == S_LDQ);
    assign data_out = (r_state == S_LDM) ? r_mcand :
                      (r_state == S_LDQ) ? r_mplier : 15'd0;
    assign ldA      = w_dec && w_nz;
    assign addsub   = w_dec && w_nz && !w_neg;
    assign Num      = (w_dec && w_nz) ? w_abs[1:0] : 2'b01;
`ifdef BOOTH8_ZERO_SKIP_EN
    assign shift    = (r_state == S_SHIFT) || (w_dec && !w_nz);
`else
    assign shift    = (r_state == S_SHIFT);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_mcand  <= 15'd0;
            r_mplier <= 15'd0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= mcand;
                        r_mplier <= mplier;
                        r_cnt    <= '0;
                        r_err    <= 1'b0;
                        r_state  <= S_CLR;
                    end
                end
                S_CLR:   r_state <= S_LDM;
                S_LDM:   r_state <= S_LDQ;
                S_LDQ:   r_state <= S_EVAL;
                S_EVAL: begin
                    if (dp_zero) begin
                        r_err   <= 1'b0;
                        r_state <= S_DONE;
                    end else if (w_cnt_max) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
`ifdef BOOTH8_ZERO_SKIP_EN
                        if (!w_nz) begin
                            r_cnt   <= r_cnt + CW'(1);
                            r_state <= S_EVAL;
                        end else begin
                            r_state <= S_SHIFT;
                        end
`else
                        r_state <= S_SHIFT;
`endif
                    end
                end
                S_SHIFT: begin
                    r_cnt   <= r_cnt + CW'(1);
                    r_state <= S_EVAL;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth8_ctrl.sv
// Bench for booth8_ctrl: behavioural datapath, digit-sweep table, random operands.
`timescale 1ns/1ps
module tb_booth8_ctrl;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [14:0] mcand, mplier;
    logic        busy, done, err, dp_rst, ldM, ldQ, ldA, shift, addsub;
    logic [14:0] data_out;
    logic [1:0]  Num;
    logic [2:0]  dp_q0;
    logic        dp_qm1, dp_zero;

    always #5 clk = ~clk;

    booth8_ctrl #(.MAX_DIGITS(8)) dut (
        .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
        .busy(busy), .done(done), .err(err), .dp_rst(dp_rst), .data_out(data_out),
        .ldM(ldM), .ldQ(ldQ), .ldA(ldA), .shift(shift), .addsub(addsub), .Num(Num),
        .dp_q0(dp_q0), .dp_qm1(dp_qm1), .dp_zero(dp_zero)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural datapath: product accumulates as sum of d_k * M * 8^k.
    longint m_P = 0, m_Q = 0, m_M = 0;
    logic   m_qm1 = 1'b0;
    int     m_k = 0;
    logic       f_en = 1'b0, f_qm1 = 1'b0;
    logic [2:0] f_q = 3'b000;

    function automatic longint coef(input logic a, input logic [1:0] n);
        longint m;
        m = (n == 2'b00) ? 64'sd4 : longint'(n);
        return a ? m : -m;
    endfunction

    always @(posedge clk) begin
        if (dp_rst) begin
            m_P <= 0; m_Q <= 0; m_qm1 <= 1'b0; m_k <= 0;
        end else begin
            if (ldM) m_M <= longint'($signed(data_out));
            if (ldQ) m_Q <= longint'($signed(data_out));
            if (ldA) m_P <= m_P + coef(addsub, Num) * (m_M <<< (3 * m_k));
            if (shift) begin
                m_qm1 <= m_Q[2];
                m_Q   <= m_Q >>> 3;
                m_k   <= m_k + 1;
            end
        end
    end

    assign dp_q0   = f_en ? f_q   : m_Q[2:0];
    assign dp_qm1  = f_en ? f_qm1 : m_qm1;
    assign dp_zero = f_en ? 1'b0  : (m_k == 6);

    // Reference Booth recoding from the sign-extended multiplier.
    function automatic int bitv(input logic [14:0] v, input int i);
        if (i < 0) return 0;
        if (i > 14) return int'(v[14]);
        return int'(v[i]);
    endfunction
    function automatic int ref_digit(input logic [14:0] v, input int k);
        return -4 * bitv(v, 3*k+2) + 2 * bitv(v, 3*k+1) + bitv(v, 3*k) + bitv(v, 3*k-1);
    endfunction
    function automatic int digit_cost(input int d);
`ifdef BOOTH8_ZERO_SKIP_EN
        return (d == 0) ? 1 : 2;
`else
        return 2;
`endif
    endfunction

    typedef struct {
        logic ldM, ldQ, ldA, shift, addsub, busy, done, err, dp_rst;
        logic [1:0]  Num;
        logic [14:0] data_out;
    } tr_t;
    tr_t tr[64];

    typedef struct {
        logic [3:0] code;
        logic       ldA;
        logic       add;
        logic [1:0] num;
    } vec_t;
    vec_t tv[16];
    int   sweep_idx = 0;
    int   sweep_cost = 0;

    task automatic run_op(input logic [14:0] mc, input logic [14:0] mp,
                          input bit glitch, input bit sweep,
                          output int done_cyc, output int n_done, output logic err_v,
                          output int n_ld, output int n_sh);
        bit prev_adv = 1'b0;
        bit apply;
        int evals = 0;
        int cur;
        done_cyc = -1; n_done = 0; err_v = 1'b0; n_ld = 0; n_sh = 0;
        start = 1'b1; mcand = mc; mplier = mp;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 64; c++) begin
            if (glitch && (c == 5 || c == 10)) begin
                start = 1'b1; mcand = 15'($urandom); mplier = 15'($urandom);
            end else begin
                start = 1'b0;
            end
            apply = sweep && prev_adv && evals < 8 && sweep_idx < 16;
            cur = sweep_idx;
            if (apply) begin
                f_q = tv[cur].code[3:1]; f_qm1 = tv[cur].code[0];
            end
            @(negedge clk);
            tr[c].ldM = ldM; tr[c].ldQ = ldQ; tr[c].ldA = ldA; tr[c].shift = shift;
            tr[c].addsub = addsub; tr[c].busy = busy; tr[c].done = done; tr[c].err = err;
            tr[c].dp_rst = dp_rst; tr[c].Num = Num; tr[c].data_out = data_out;
            chk("ldA_shift_excl", longint'(ldA & shift), 0);
            if (apply) begin
                chk($sformatf("sweep_%b_ldA", tv[cur].code), longint'(ldA), longint'(tv[cur].ldA));
                if (tv[cur].ldA) begin
                    chk($sformatf("sweep_%b_addsub", tv[cur].code), longint'(addsub), longint'(tv[cur].add));
                    chk($sformatf("sweep_%b_Num", tv[cur].code), longint'(Num), longint'(tv[cur].num));
                end
                sweep_cost += digit_cost(tv[cur].ldA ? 1 : 0);
                sweep_idx++; evals++;
            end
            prev_adv = ldQ | shift;
            if (ldA) n_ld++;
            if (shift) n_sh++;
            if (done) begin
                n_done++;
                if (done_cyc < 0) begin done_cyc = c; err_v = err; end
            end
            @(posedge clk); #1;
            if (done_cyc > 0 && c >= done_cyc + 1) break;
        end
        start = 1'b0;
        if (done_cyc < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic verify_op(input string tag, input logic [14:0] mc, input logic [14:0] mp,
                             input bit glitch);
        int dc, nd, nl, ns, exp_dc, exp_ld;
        logic ev;
        int d;
        longint exp_p;
        exp_dc = 5; exp_ld = 0;
        for (int k = 0; k < 6; k++) begin
            d = ref_digit(mp, k);
            exp_dc += digit_cost(d);
            if (d != 0) exp_ld++;
        end
        exp_p = longint'($signed(mc)) * longint'($signed(mp));
        run_op(mc, mp, glitch, 1'b0, dc, nd, ev, nl, ns);
        chk({tag, "_product"}, m_P, exp_p);
        chk({tag, "_done_cyc"}, dc, exp_dc);
        chk({tag, "_err"}, longint'(ev), 0);
        chk({tag, "_n_ldA"}, nl, exp_ld);
        chk({tag, "_n_shift"}, ns, 6);
        chk({tag, "_n_done"}, nd, 1);
        $display("op %s mcand=%0d mplier=%0d product=%0d done_cyc=%0d", tag,
                 $signed(mc), $signed(mp), m_P, dc);
    endtask

    initial begin
        int dc, nd, nl, ns, d;
        logic ev;
        tv[0]  = '{4'b0000, 1'b0, 1'b0, 2'b01};
        tv[1]  = '{4'b0001, 1'b1, 1'b1, 2'b01};
        tv[2]  = '{4'b0010, 1'b1, 1'b1, 2'b01};
        tv[3]  = '{4'b0011, 1'b1, 1'b1, 2'b10};
        tv[4]  = '{4'b0100, 1'b1, 1'b1, 2'b10};
        tv[5]  = '{4'b0101, 1'b1, 1'b1, 2'b11};
        tv[6]  = '{4'b0110, 1'b1, 1'b1, 2'b11};
        tv[7]  = '{4'b0111, 1'b1, 1'b1, 2'b00};
        tv[8]  = '{4'b1000, 1'b1, 1'b0, 2'b00};
        tv[9]  = '{4'b1001, 1'b1, 1'b0, 2'b11};
        tv[10] = '{4'b1010, 1'b1, 1'b0, 2'b11};
        tv[11] = '{4'b1011, 1'b1, 1'b0, 2'b10};
        tv[12] = '{4'b1100, 1'b1, 1'b0, 2'b10};
        tv[13] = '{4'b1101, 1'b1, 1'b0, 2'b01};
        tv[14] = '{4'b1110, 1'b1, 1'b0, 2'b01};
        tv[15] = '{4'b1111, 1'b0, 1'b0, 2'b01};

        rst = 1'b1; start = 1'b0; mcand = 15'd0; mplier = 15'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", longint'(busy), 0);   chk("rst_done", longint'(done), 0);
        chk("rst_err", longint'(err), 0);     chk("rst_ldM", longint'(ldM), 0);
        chk("rst_ldQ", longint'(ldQ), 0);     chk("rst_ldA", longint'(ldA), 0);
        chk("rst_shift", longint'(shift), 0); chk("rst_addsub", longint'(addsub), 0);
        chk("rst_Num", longint'(Num), 1);     chk("rst_data_out", longint'(data_out), 0);
        chk("rst_dp_rst", longint'(dp_rst), 1);
        $display("reset checked");
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("idle_dp_rst", longint'(dp_rst), 0);
        chk("idle_busy", longint'(busy), 0);
        @(posedge clk); #1;

        // Directed 5 x 7 with per-cycle strobe checks.
        verify_op("m5x7", 15'd5, 15'd7, 1'b0);
        chk("m5x7_c1_dp_rst", longint'(tr[1].dp_rst), 1);
        chk("m5x7_c1_busy", longint'(tr[1].busy), 1);
        chk("m5x7_c2_dp_rst", longint'(tr[2].dp_rst), 0);
        chk("m5x7_c2_ldM", longint'(tr[2].ldM), 1);
        chk("m5x7_c2_data", longint'(tr[2].data_out), 5);
        chk("m5x7_c3_ldQ", longint'(tr[3].ldQ), 1);
        chk("m5x7_c3_data", longint'(tr[3].data_out), 7);
        chk("m5x7_c4_data", longint'(tr[4].data_out), 0);
        d = ref_digit(15'd7, 0);
        chk("m5x7_eval_ldA", longint'(tr[4].ldA), longint'(d != 0));
        chk("m5x7_eval_addsub", longint'(tr[4].addsub), longint'(d > 0));
        chk("m5x7_eval_Num", longint'(tr[4].Num), longint'((d < 0 ? -d : d) % 4));

        // Forced digit sweep; dp_zero held low, so each op ends on the watchdog.
        f_en = 1'b1;
        for (int r = 0; r < 2; r++) begin
            sweep_cost = 0;
            run_op(15'd3, 15'd1, 1'b0, 1'b1, dc, nd, ev, nl, ns);
            chk($sformatf("sweep%0d_err", r), longint'(ev), 1);
            chk($sformatf("sweep%0d_n_shift", r), ns, 8);
            chk($sformatf("sweep%0d_done_cyc", r), dc, 5 + sweep_cost);
            $display("watchdog op %0d done_cyc=%0d err=%0d shifts=%0d", r, dc, ev, ns);
        end
        chk("sweep_all_applied", sweep_idx, 16);
        f_en = 1'b0;

        verify_op("glitch", 15'(1234), 15'(32000), 1'b1);
        verify_op("zero_mplier", 15'(77), 15'd0, 1'b0);

        // Reset asserted in cycle 7 of a running operation.
        start = 1'b1; mcand = 15'd9; mplier = 15'd11;
        @(posedge clk); #1; start = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_busy", longint'(busy), 0);
        chk("midrst_dp_rst", longint'(dp_rst), 1);
        chk("midrst_strobes", longint'({ldA, shift, ldM, ldQ, done}), 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("midrst_idle_busy", longint'(busy), 0);
        @(posedge clk); #1;
        $display("mid-op reset checked");
        verify_op("after_rst", 15'd9, 15'd11, 1'b0);

        for (int i = 0; i < 12; i++)
            verify_op($sformatf("rand%0d", i), 15'($urandom), 15'($urandom), 1'b0);
        verify_op("neg_edge", 15'h4000, 15'h4000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
